ntt_addr_gen: RTL and testbench
===============================

NTT_ADDR_GEN -- requirements
Module: ntt_addr_gen

Interface
REQ-001 SHALL have parameter BF_LATENCY, default 4, butterfly pipeline depth in cycles (1..15), used only when NTT_AG_LAYER_SYNC_EN is defined.
REQ-002 SHALL have port clk_i, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port rst_n_i, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start_i, input, 1, start pulse; sampled only in IDLE.
REQ-005 SHALL have port mode_i, input, 1, 0 = q 3329 (7 layers), 1 = q 8380417 (8 layers); latched at start.
REQ-006 SHALL have port inv_i, input, 1, 0 = forward (CT), 1 = inverse (GS); latched at start.
REQ-007 SHALL have port stall_i, input, 1, downstream back-pressure; the current issue is accepted when valid_o=1 and stall_i=0.
REQ-008 SHALL have ports addr_a_o and addr_b_o, output, 8 each, coefficient indices for the butterfly a and b operands.
REQ-009 SHALL have port tw_idx_o, output, 8, twiddle ROM index.
REQ-010 SHALL have ports sel_mul_o and sel_butterfly_o, output, 1 each, equal to latched mode_i and inv_i, held for the whole transform.
REQ-011 SHALL have ports layer_o (output, 3, current layer 0..7), valid_o, busy_o and done_o (output, 1 each).

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DRAIN and DONE: IDLE->RUN on start_i; RUN->DRAIN at a layer end (macro only); DRAIN->RUN after BF_LATENCY cycles; RUN->DONE on the last accepted issue; DONE->IDLE after one cycle.
REQ-013 SHALL drive all outputs from registers; the first valid_o occurs the cycle after start_i is sampled.
REQ-014 SHALL ignore start_i while busy_o=1; busy_o=1 in RUN and DRAIN.
REQ-015 Per layer with half-length len, SHALL issue 128 butterflies in group-major order (groups start=0,2len,4len...; j=start..start+len-1) with addr_a_o=j and addr_b_o=j+len.
REQ-016 Forward len sequence SHALL be 128,64,...,2 (mode 0) or 128,...,1 (mode 1); inverse SHALL be the reverse order.
REQ-017 Forward tw_idx_o SHALL start at 1 and increment once per group across layers; inverse SHALL start at 2^L-1 (L = layer count) and decrement once per group, ending at 1.
REQ-018 While valid_o=1 and stall_i=1, SHALL hold every output and counter unchanged.
REQ-019 SHALL assert done_o for exactly one cycle (DONE state), the cycle after the final accepted issue; valid_o=0 in DONE.
REQ-020 layer_o SHALL count 0..L-1 in issue order regardless of direction.
REQ-021 Throughput SHALL be one issue per cycle without stalls: 896 cycles (mode 0) or 1024 cycles (mode 1) from first valid_o to last valid_o.

Reset
REQ-022 On rst_n_i=0, SHALL immediately enter IDLE, including mid-transform, with every output 0; no state survives reset.
REQ-023 After reset release, SHALL stay in IDLE until a start_i sampled on a rising edge.

Configuration
REQ-024 With NTT_AG_LAYER_SYNC_EN defined, SHALL insert DRAIN for BF_LATENCY cycles (valid_o=0, busy_o=1) between consecutive layers, but not after the last layer.
REQ-025 Without NTT_AG_LAYER_SYNC_EN, SHALL have no DRAIN state, and layers SHALL issue back-to-back.

Verification
REQ-026 Stimulus: mode=0, inv=0, no stall -> first issue a=0, b=128, tw=1; issue 128 a=0, b=64, tw=2; last issue a=253, b=255, tw=127, layer 6; done_o after 896 issues.
REQ-027 Stimulus: mode=1, inv=0 -> last layer issues pairs (2k, 2k+1); final issue a=254, b=255, tw=255, layer 7.
REQ-028 Stimulus: mode=1, inv=1 -> first issue a=0, b=1, tw=255; final issue a=127, b=255, tw=1; sel_butterfly_o=1 and sel_mul_o=1 throughout.
REQ-029 Stimulus: stall_i=1 for 5 cycles at issue 300 -> outputs frozen for those cycles; the sequence resumes unchanged; done_o is delayed by exactly 5 cycles.
REQ-030 Stimulus: rst_n_i=0 at issue 500, then a new start -> outputs 0 immediately; the restart begins again at a=0, b=128, tw=1.
REQ-031 Stimulus: macro defined, BF_LATENCY=4, mode=0 -> 4 idle cycles at each of 6 layer boundaries; 920 cycles from first to last valid_o; start_i during the run is ignored.

Source files
------------

// File: rtl/ntt_addr_gen.sv
// ntt_addr_gen: address and twiddle-index sequencer for an in-place NTT/INTT.
// Issues one butterfly (a, b, twiddle) per cycle, in group-major order, over
// 7 layers (q = 3329) or 8 layers (q = 8380417), forward (CT) or inverse (GS).
// Optional feature: define NTT_AG_LAYER_SYNC_EN to insert BF_LATENCY idle
// DRAIN cycles between layers so the butterfly pipeline empties first.
module ntt_addr_gen #(
  parameter int BF_LATENCY = 4
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  logic       inv_i,
  input  logic       stall_i,
  output logic [7:0] addr_a_o,
  output logic [7:0] addr_b_o,
  output logic [7:0] tw_idx_o,
  output logic       sel_mul_o,
  output logic       sel_butterfly_o,
  output logic [2:0] layer_o,
  output logic       valid_o,
  output logic       busy_o,
  output logic       done_o
);

`ifdef NTT_AG_LAYER_SYNC_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3} state_t;
  localparam logic [3:0] LP_DRAIN_LAST = 4'(BF_LATENCY - 1);
  logic [3:0] r_drain;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd3} state_t;
  // BF_LATENCY only matters when layers are separated by DRAIN.
  logic w_unused_bf;
  assign w_unused_bf = ^BF_LATENCY;
`endif

  state_t     r_state, w_nxt;
  logic       r_mode, r_inv, r_valid, r_busy, r_done;
  logic [2:0] r_layer;
  logic [7:0] r_len, r_base, r_off, r_a, r_b, r_tw;

  logic       w_acc, w_grp_end, w_lay_end, w_last;
  logic [8:0] w_base2;
  logic [7:0] w_len_nxt, w_tw_nxt, w_len_init, w_tw_init;

  assign addr_a_o        = r_a;
  assign addr_b_o        = r_b;
  assign tw_idx_o        = r_tw;
  assign sel_mul_o       = r_mode;
  assign sel_butterfly_o = r_inv;
  assign layer_o         = r_layer;
  assign valid_o         = r_valid;
  assign busy_o          = r_busy;
  assign done_o          = r_done;

  // Sequence bookkeeping: where the current issue sits in its group/layer.
  always_comb begin
    w_acc      = (r_state == S_RUN) && !stall_i;
    w_grp_end  = (r_off == r_len - 8'd1);
    // Next group base; bit 8 set means this was the last group of the layer.
    w_base2    = {1'b0, r_base} + {r_len, 1'b0};
    w_lay_end  = w_grp_end && w_base2[8];
    w_last     = w_lay_end && (r_layer == (r_mode ? 3'd7 : 3'd6));
    w_len_nxt  = r_inv ? {r_len[6:0], 1'b0} : {1'b0, r_len[7:1]};
    w_tw_nxt   = r_inv ? r_tw - 8'd1 : r_tw + 8'd1;
    w_len_init = inv_i ? (mode_i ? 8'd1 : 8'd2) : 8'd128;
    w_tw_init  = inv_i ? (mode_i ? 8'd255 : 8'd127) : 8'd1;
  end

  // Next-state logic.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (start_i) w_nxt = S_RUN;
      S_RUN: begin
        if (w_acc && w_last) w_nxt = S_DONE;
`ifdef NTT_AG_LAYER_SYNC_EN
        else if (w_acc && w_lay_end) w_nxt = S_DRAIN;
`endif
      end
`ifdef NTT_AG_LAYER_SYNC_EN
      S_DRAIN: if (r_drain == 4'd0) w_nxt = S_RUN;
`endif
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // State register plus status flags registered from the next state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_valid <= (w_nxt == S_RUN);
`ifdef NTT_AG_LAYER_SYNC_EN
      r_busy  <= (w_nxt == S_RUN) || (w_nxt == S_DRAIN);
`else
      r_busy  <= (w_nxt == S_RUN);
`endif
      r_done  <= (w_nxt == S_DONE);
    end
  end

  // Address / twiddle counters; frozen whenever an issue is not accepted.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_mode  <= 1'b0;
      r_inv   <= 1'b0;
      r_layer <= 3'd0;
      r_len   <= 8'd0;
      r_base  <= 8'd0;
      r_off   <= 8'd0;
      r_a     <= 8'd0;
      r_b     <= 8'd0;
      r_tw    <= 8'd0;
    end else if (r_state == S_IDLE) begin
      if (start_i) begin
        r_mode  <= mode_i;
        r_inv   <= inv_i;
        r_layer <= 3'd0;
        r_len   <= w_len_init;
        r_base  <= 8'd0;
        r_off   <= 8'd0;
        r_a     <= 8'd0;
        r_b     <= w_len_init;
        r_tw    <= w_tw_init;
      end
    end else if (w_acc && !w_last) begin
      if (w_lay_end) begin
        r_layer <= r_layer + 3'd1;
        r_len   <= w_len_nxt;
        r_base  <= 8'd0;
        r_off   <= 8'd0;
        r_a     <= 8'd0;
        r_b     <= w_len_nxt;
        r_tw    <= w_tw_nxt;
      end else if (w_grp_end) begin
        r_base  <= w_base2[7:0];
        r_off   <= 8'd0;
        r_a     <= w_base2[7:0];
        r_b     <= w_base2[7:0] + r_len;
        r_tw    <= w_tw_nxt;
      end else begin
        r_off   <= r_off + 8'd1;
        r_a     <= r_a + 8'd1;
        r_b     <= r_b + 8'd1;
      end
    end
  end

`ifdef NTT_AG_LAYER_SYNC_EN
  // Drain countdown, loaded as a layer boundary is crossed.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                                  r_drain <= 4'd0;
    else if (w_acc && w_lay_end && !w_last)        r_drain <= LP_DRAIN_LAST;
    else if (r_state == S_DRAIN && r_drain != 4'd0) r_drain <= r_drain - 4'd1;
  end
`endif

endmodule

// File: tb/tb_ntt_addr_gen.sv
// tb_ntt_addr_gen: scoreboard bench; the expected issue stream is built from
// nested layer/group/index loops and compared against every visible issue.
module tb_ntt_addr_gen;
  localparam int BFL = 4;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] tw;
    logic [2:0] layer;
  } issue_t;

  logic       clk = 1'b0;
  logic       rst_n_i = 1'b1;
  logic       start_i = 1'b0, mode_i = 1'b0, inv_i = 1'b0, stall_i = 1'b0;
  logic [7:0] addr_a_o, addr_b_o, tw_idx_o;
  logic       sel_mul_o, sel_butterfly_o, valid_o, busy_o, done_o;
  logic [2:0] layer_o;

  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  issue_t exp_q[$];

  ntt_addr_gen #(.BF_LATENCY(BFL)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .start_i(start_i), .mode_i(mode_i),
    .inv_i(inv_i), .stall_i(stall_i), .addr_a_o(addr_a_o), .addr_b_o(addr_b_o),
    .tw_idx_o(tw_idx_o), .sel_mul_o(sel_mul_o), .sel_butterfly_o(sel_butterfly_o),
    .layer_o(layer_o), .valid_o(valid_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic issue_t mk(input int a, input int b, input int tw, input int l);
    issue_t e;
    e.a = 8'(a); e.b = 8'(b); e.tw = 8'(tw); e.layer = 3'(l);
    return e;
  endfunction

  // Reference stream: layer -> group start -> index within group.
  task automatic push_expected(input logic m, input logic iv);
    int L, len, tw;
    L  = m ? 8 : 7;
    tw = iv ? (1 << L) - 1 : 1;
    for (int li = 0; li < L; li++) begin
      len = iv ? ((m ? 1 : 2) << li) : (128 >> li);
      for (int st = 0; st < 256; st += 2 * len) begin
        for (int j = st; j < st + len; j++) exp_q.push_back(mk(j, j + len, tw, li));
        tw = iv ? tw - 1 : tw + 1;
      end
    end
  endtask

  function automatic int drain_exp(input logic m);
`ifdef NTT_AG_LAYER_SYNC_EN
    return (m ? 7 : 6) * BFL;
`else
    return 0 * int'(m);
`endif
  endfunction

  // One full transform, checked issue by issue. stall_at/ping_at/abort_at < 0 disable.
  task automatic run_xfer(input string nm, input logic m, input logic iv,
                          input int stall_at, input int ping_at, input int abort_at,
                          output issue_t first_obs, output issue_t last_obs);
    int N, k, start_edge, first_c, last_c, done_c, done_n, stall_left, drain_n, nprint, xtra;
    bit fin, stall_used;
    issue_t e, got;
    exp_q.delete();
    push_expected(m, iv);
    N = m ? 1024 : 896;
    xtra = (stall_at >= 0 ? 5 : 0) + drain_exp(m);
    k = 0; first_c = -1; last_c = -1; done_c = -1; done_n = 0;
    stall_left = 0; drain_n = 0; nprint = 0; fin = 0; stall_used = 0;
    first_obs = '0; last_obs = '0;
    @(negedge clk);
    mode_i = m; inv_i = iv; start_i = 1'b1;
    start_edge = cyc + 1;
    for (int bud = 0; bud < 1300 && !fin; bud++) begin
      @(negedge clk);
      start_i = 1'b0; stall_i = 1'b0;
      mode_i = ~m; inv_i = ~iv;               // must already be latched
      if (ping_at >= 0 && k == ping_at) start_i = 1'b1;
      got = {addr_a_o, addr_b_o, tw_idx_o, layer_o};
      if (valid_o) begin
        if (first_c < 0) begin first_c = cyc; first_obs = got; end
        last_c = cyc; last_obs = got;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          if (nprint++ < 8) $display("FAIL %s extra_issue: got valid issue a=%0d after sequence end", nm, addr_a_o);
        end else begin
          e = exp_q[0];
          if ({got, sel_mul_o, sel_butterfly_o, busy_o, done_o} !== {e, m, iv, 1'b1, 1'b0}) begin
            n_fail++;
            if (nprint++ < 8)
              $display("FAIL %s issue %0d: got a=%0d b=%0d tw=%0d ly=%0d mul=%b bf=%b busy=%b done=%b, want a=%0d b=%0d tw=%0d ly=%0d mul=%b bf=%b busy=1 done=0",
                       nm, k, addr_a_o, addr_b_o, tw_idx_o, layer_o, sel_mul_o, sel_butterfly_o, busy_o, done_o,
                       e.a, e.b, e.tw, e.layer, m, iv);
          end
        end
        if (abort_at == k) begin
          rst_n_i = 1'b0;
          #1;
          n_tests++;
          if ({addr_a_o, addr_b_o, tw_idx_o, layer_o, sel_mul_o, sel_butterfly_o, valid_o, busy_o, done_o} !== '0) begin
            n_fail++;
            $display("FAIL %s async_reset: got a=%0d b=%0d tw=%0d ly=%0d v=%b busy=%b, want all 0",
                     nm, addr_a_o, addr_b_o, tw_idx_o, layer_o, valid_o, busy_o);
          end
          return;
        end
        if (stall_at == k && !stall_used) begin stall_used = 1; stall_left = 5; end
        if (stall_left > 0) begin stall_i = 1'b1; stall_left--; end
        else if (exp_q.size() != 0) begin void'(exp_q.pop_front()); k++; end
      end else if (busy_o) drain_n++;
      if (done_o) begin
        done_n++;
        if (done_c < 0) done_c = cyc;
      end
      if (done_c >= 0 && cyc > done_c + 1) fin = 1;
    end
    stall_i = 1'b0; start_i = 1'b0;
    n_tests++;
    if (!fin) begin
      n_fail++;
      $display("FAIL %s timeout: got no done_o within budget (issues seen %0d), want done", nm, k);
      return;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s missing_issues: got %0d left unissued, want 0", nm, exp_q.size());
    end
    n_tests++;
    if (done_n != 1) begin
      n_fail++; $display("FAIL %s done_pulse: got %0d cycles of done_o, want 1", nm, done_n);
    end
    n_tests++;
    if (done_c - start_edge != N + xtra) begin
      n_fail++; $display("FAIL %s done_latency: got %0d, want %0d", nm, done_c - start_edge, N + xtra);
    end
    n_tests++;
    if (first_c != start_edge || last_c - first_c + 1 != N + xtra) begin
      n_fail++;
      $display("FAIL %s valid_span: got first@%0d span %0d, want first@%0d span %0d",
               nm, first_c, last_c - first_c + 1, start_edge, N + xtra);
    end
    n_tests++;
    if (drain_n != drain_exp(m)) begin
      n_fail++; $display("FAIL %s drain_cycles: got %0d, want %0d", nm, drain_n, drain_exp(m));
    end
    n_tests++;
    if ({valid_o, busy_o, done_o} !== 3'b000) begin
      n_fail++; $display("FAIL %s idle_after_done: got v/busy/done=%b, want 000", nm, {valid_o, busy_o, done_o});
    end
  endtask

  task automatic chk_obs(input string nm, input issue_t got, input issue_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got a=%0d b=%0d tw=%0d ly=%0d, want a=%0d b=%0d tw=%0d ly=%0d",
               nm, got.a, got.b, got.tw, got.layer, want.a, want.b, want.tw, want.layer);
    end
  endtask

  task automatic test_reset();
    #3 rst_n_i = 1'b0;
    #1;
    n_tests++;
    if ({addr_a_o, addr_b_o, tw_idx_o, layer_o, sel_mul_o, sel_butterfly_o, valid_o, busy_o, done_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got a=%0d v=%b busy=%b done=%b, want all 0", addr_a_o, valid_o, busy_o, done_o);
    end
    @(negedge clk); @(negedge clk);
    rst_n_i = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({valid_o, busy_o, done_o} !== 3'b000) begin
      n_fail++; $display("FAIL idle_after_reset: got v/busy/done=%b, want 000", {valid_o, busy_o, done_o});
    end
  endtask

  task automatic test_fwd_q3329();
    issue_t f, l;
    run_xfer("fwd_m0", 1'b0, 1'b0, -1, -1, -1, f, l);
    chk_obs("fwd_m0_first", f, mk(0, 128, 1, 0));
    chk_obs("fwd_m0_last", l, mk(253, 255, 127, 6));
  endtask

  task automatic test_fwd_q8380417();
    issue_t f, l;
    run_xfer("fwd_m1_ping", 1'b1, 1'b0, -1, 100, -1, f, l);
    chk_obs("fwd_m1_last", l, mk(254, 255, 255, 7));
  endtask

  task automatic test_inv();
    issue_t f, l;
    run_xfer("inv_m1", 1'b1, 1'b1, -1, -1, -1, f, l);
    chk_obs("inv_m1_first", f, mk(0, 1, 255, 0));
    chk_obs("inv_m1_last", l, mk(127, 255, 1, 7));
    run_xfer("inv_m0", 1'b0, 1'b1, -1, -1, -1, f, l);
    chk_obs("inv_m0_first", f, mk(0, 2, 127, 0));
    chk_obs("inv_m0_last", l, mk(127, 255, 1, 6));
  endtask

  task automatic test_stall();
    issue_t f, l;
    run_xfer("stall300", 1'b0, 1'b0, 300, -1, -1, f, l);
    chk_obs("stall300_last", l, mk(253, 255, 127, 6));
  endtask

  task automatic test_abort_restart();
    issue_t f, l;
    run_xfer("abort500", 1'b0, 1'b0, -1, -1, 500, f, l);
    @(negedge clk);
    n_tests++;
    if ({valid_o, busy_o, addr_a_o} !== '0) begin
      n_fail++; $display("FAIL abort_hold: got v=%b busy=%b a=%0d in reset, want 0", valid_o, busy_o, addr_a_o);
    end
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk);
    run_xfer("restart", 1'b0, 1'b0, -1, -1, -1, f, l);
    chk_obs("restart_first", f, mk(0, 128, 1, 0));
  endtask

  initial begin
    test_reset();
    test_fwd_q3329();
    test_fwd_q8380417();
    test_inv();
    test_stall();
    test_abort_restart();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
